// File: rtl/vpm_pipe_feeder.sv
// vpm_pipe_feeder: DEPTH-entry circular FIFO feeding a single output register
// that drives the first pipeline stage (data_I / valid_I).
// The stage advances when flush_n_I=1 and stall_I=0; a flush clears valid_I
// without popping, and a stall holds the output register.
// Optional build macro VPM_PIPE_FEEDER_LEVEL_EN adds the level and overrun outputs.
module vpm_pipe_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  stall_I,
  input  logic                  flush_n_I,
  output logic [DATA_WIDTH-1:0] data_I,
  output logic                  valid_I
`ifdef VPM_PIPE_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic w_push;
  logic w_advance;
  logic w_pop;
  logic w_full;

  // Handshake and stage-control decode; in_ready depends on registered count only
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_push    = in_valid && !w_full;
    w_advance = flush_n_I && !stall_I;
    w_pop     = w_advance && (r_count != '0);
  end

  assign in_ready = !w_full;
  assign data_I   = r_data;
  assign valid_I  = r_valid;

  // FIFO storage write; never read before written, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy count: unchanged on simultaneous push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: flush beats stall, stall holds, advance pops or bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (!flush_n_I) begin
      r_valid <= 1'b0;
    end else if (!stall_I) begin
      if (r_count != '0) begin
        r_data  <= r_mem[r_rd_ptr];
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef VPM_PIPE_FEEDER_LEVEL_EN
  logic r_overrun;

  assign level   = r_count;
  assign overrun = r_overrun;

  // Sticky flag for an offer made while the FIFO is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/vpm_pipe_feeder.md
VPM_PIPE_FEEDER -- requirements
Module: vpm_pipe_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving FIFO entries; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream producer offers in_data.
REQ-006 The block SHALL have port in_data, input, DATA_WIDTH bits, the upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-008 The block SHALL have port stall_I, input, 1 bit, the first-stage stall from the downstream pipeline hazard logic.
REQ-009 The block SHALL have port flush_n_I, input, 1 bit, the active-low first-stage flush.
REQ-010 The block SHALL have port data_I, output, DATA_WIDTH bits, the payload driven into the first pipeline stage.
REQ-011 The block SHALL have port valid_I, output, 1 bit, meaning data_I holds a live item.

Function
REQ-012 The block SHALL combine a DEPTH-entry circular FIFO with one output register that drives data_I and valid_I.
REQ-013 The block SHALL drive in_ready = (count != DEPTH), decoded from registered state only, with no combinational path from stall_I or flush_n_I.
REQ-014 A push SHALL occur on an edge where in_valid && in_ready; in_data is written at wr_ptr, and wr_ptr then increments modulo DEPTH.
REQ-015 The stage SHALL "advance" on an edge where flush_n_I=1 and stall_I=0.
REQ-016 On advance with count>0, the block SHALL pop: load the entry at rd_ptr into data_I, set valid_I=1, and increment rd_ptr modulo DEPTH.
REQ-017 On advance with count=0, the block SHALL set valid_I=0 and leave data_I unchanged.
REQ-018 When stall_I=1 and flush_n_I=1, the block SHALL hold data_I and valid_I and SHALL NOT pop; pushes still proceed.
REQ-019 When flush_n_I=0, the block SHALL clear valid_I and SHALL NOT pop, regardless of stall_I (flush beats stall); FIFO contents are kept; pushes still proceed.
REQ-020 On a simultaneous push and pop, count SHALL be unchanged; otherwise count changes by +1 on push or -1 on pop.
REQ-021 Minimum latency SHALL be 2 edges: an item accepted at edge N appears on data_I with valid_I=1 after edge N+1, provided the FIFO was empty and the stage advances at N+1.
REQ-022 Items SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 without a bubble.
REQ-024 When full, the block SHALL keep in_ready=0 even if a pop occurs on the same edge; in_ready rises the cycle after that pop.

Reset
REQ-025 While rst=1, the block SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, valid_I=0 and data_I=0, which gives in_ready=1.
REQ-026 Asserting rst mid-operation SHALL discard all FIFO contents and the in-flight output item.
REQ-027 The block SHALL make no push and no pop on the first edge after rst deasserts unless the handshake conditions hold.
REQ-028 FIFO storage SHALL need no reset; it is never read before being written.

Configuration
REQ-029 With macro VPM_PIPE_FEEDER_LEVEL_EN defined, the block SHALL add output level, $clog2(DEPTH)+1 bits, equal to registered count (reset value 0).
REQ-030 With VPM_PIPE_FEEDER_LEVEL_EN defined, the block SHALL add output overrun, 1 bit, a sticky flag set when in_valid=1 && in_ready=0 and cleared only by rst.
REQ-031 Without VPM_PIPE_FEEDER_LEVEL_EN, neither level nor overrun SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Single item: rst pulse; in_data=8'hA5 with in_valid for 1 cycle, stall_I=0, flush_n_I=1 -> data_I=8'hA5, valid_I=1 two edges after the push, then valid_I=0 on the next edge.
REQ-033 Fill and stall: stall_I=1; push 8'h01..8'h05 back-to-back -> in_ready=0 after 4 accepts, 8'h05 not accepted, valid_I=0; release stall -> data_I sequence 01,02,03,04 on consecutive edges.
REQ-034 Stall hold: during streaming, stall_I=1 for 3 cycles while data_I=8'h10 -> data_I stays 8'h10 with valid_I=1 for all 3 cycles, then 8'h11 follows.
REQ-035 Flush: data_I=8'h20 valid, FIFO holding 21,22; flush_n_I=0 with stall_I=1 for 1 cycle -> valid_I=0, then 8'h21 and 8'h22 on the next advances.
REQ-036 Wrap and concurrency: 20 items with random in_valid and 30% random stall_I -> outputs match a scoreboard in order, count stays at or below DEPTH, pointers wrap at least 4 times.
REQ-037 Async reset: with FIFO at 3 entries and valid_I=1, assert rst mid-cycle -> valid_I=0 and in_ready=1 before the next edge; with LEVEL_EN defined, level=0 and overrun=0.
